// File: rtl/lc3_mem_responder.sv
// Behavioural instruction/data memory responder for the LC3 core: two independent
// request FSMs with a fixed wait-state count, plus a bench-side preload port.
module lc3_mem_responder #(
  parameter int IMEM_AW     = 8,
  parameter int DMEM_AW     = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] pc,
  input  logic        instrmem_rd,
  output logic [15:0] Instr_dout,
  output logic        complete_instr,
  input  logic [15:0] Data_addr,
  input  logic [15:0] Data_din,
  input  logic        Data_rd,
  input  logic        Data_req,
  output logic [15:0] Data_dout,
  output logic        complete_data,
  input  logic        load_en,
  input  logic        load_sel,
  input  logic [15:0] load_addr,
  input  logic [15:0] load_data
);

  localparam logic [2:0] WC = 3'(WAIT_CYCLES);
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {I_IDLE, I_WAIT, I_DONE} i_state_t;
  typedef enum logic [1:0] {D_IDLE, D_WAIT, D_DONE} d_state_t;

  logic [15:0] imem [2**IMEM_AW];
  logic [15:0] dmem [2**DMEM_AW];

  i_state_t           i_state, i_state_nx;
  logic [2:0]         i_cnt, i_cnt_nx;
  logic [IMEM_AW-1:0] i_addr, i_addr_nx;
  logic [15:0]        i_hold, i_hold_nx;

  d_state_t           d_state, d_state_nx;
  logic [2:0]         d_cnt, d_cnt_nx;
  logic [DMEM_AW-1:0] d_addr, d_addr_nx;
  logic               d_rd, d_rd_nx;
  logic [15:0]        d_din, d_din_nx;
  logic [15:0]        d_hold, d_hold_nx;
  logic               dmem_we;

  // Upper address bits are intentionally dropped so accesses wrap.
  logic unused_hi;
  assign unused_hi = ^{pc, Data_addr, load_addr};

  always_ff @(posedge clock) begin
    if (reset) begin
      i_state <= I_IDLE;
      i_cnt   <= '0;
      i_addr  <= '0;
      i_hold  <= '0;
      d_state <= D_IDLE;
      d_cnt   <= '0;
      d_addr  <= '0;
      d_rd    <= 1'b0;
      d_din   <= '0;
      d_hold  <= '0;
    end else begin
      i_state <= i_state_nx;
      i_cnt   <= i_cnt_nx;
      i_addr  <= i_addr_nx;
      i_hold  <= i_hold_nx;
      d_state <= d_state_nx;
      d_cnt   <= d_cnt_nx;
      d_addr  <= d_addr_nx;
      d_rd    <= d_rd_nx;
      d_din   <= d_din_nx;
      d_hold  <= d_hold_nx;
    end
  end

  // Read data is taken combinationally in DONE, so a preload landing in the
  // request cycle is already visible (write-first) and output timing is exact.
  always_comb begin
    i_state_nx     = i_state;
    i_cnt_nx       = i_cnt;
    i_addr_nx      = i_addr;
    i_hold_nx      = i_hold;
    Instr_dout     = i_hold;
    complete_instr = 1'b0;
    case (i_state)
      I_IDLE: begin
        if (instrmem_rd) begin
          i_addr_nx  = pc[IMEM_AW-1:0];
          i_cnt_nx   = WC;
          i_state_nx = NO_WAIT ? I_DONE : I_WAIT;
        end
      end
      I_WAIT: begin
        i_cnt_nx = i_cnt - 3'd1;
        if (i_cnt <= 3'd1) i_state_nx = I_DONE;
      end
      I_DONE: begin
        Instr_dout     = imem[i_addr];
        i_hold_nx      = imem[i_addr];
        complete_instr = 1'b1;
        i_state_nx     = I_IDLE;
      end
      default: i_state_nx = I_IDLE;
    endcase
  end

  always_comb begin
    d_state_nx    = d_state;
    d_cnt_nx      = d_cnt;
    d_addr_nx     = d_addr;
    d_rd_nx       = d_rd;
    d_din_nx      = d_din;
    d_hold_nx     = d_hold;
    Data_dout     = d_hold;
    complete_data = 1'b0;
    dmem_we       = 1'b0;
    case (d_state)
      D_IDLE: begin
        if (Data_req) begin
          d_addr_nx  = Data_addr[DMEM_AW-1:0];
          d_rd_nx    = Data_rd;
          d_din_nx   = Data_din;
          d_cnt_nx   = WC;
          d_state_nx = NO_WAIT ? D_DONE : D_WAIT;
        end
      end
      D_WAIT: begin
        d_cnt_nx = d_cnt - 3'd1;
        if (d_cnt <= 3'd1) d_state_nx = D_DONE;
      end
      D_DONE: begin
        complete_data = 1'b1;
        if (d_rd) begin
          Data_dout = dmem[d_addr];
          d_hold_nx = dmem[d_addr];
        end else begin
          dmem_we = 1'b1;
        end
        d_state_nx = D_IDLE;
      end
      default: d_state_nx = D_IDLE;
    endcase
  end

  // Preload only lands while both sides are idle; a data write only happens
  // in D_DONE, so the two dmem writers can never collide.
  always_ff @(posedge clock) begin
    if (!reset && load_en && i_state == I_IDLE && d_state == D_IDLE) begin
      if (load_sel) dmem[load_addr[DMEM_AW-1:0]] <= load_data;
      else          imem[load_addr[IMEM_AW-1:0]] <= load_data;
    end
    if (!reset && dmem_we) dmem[d_addr] <= d_din;
  end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Bench for lc3_mem_responder: four instances (WAIT_CYCLES 0..3) share stimulus and
// are checked every cycle against a transaction-level model keyed by completion cycle.
module tb_lc3_mem_responder;
  localparam int N = 4;

  logic        clock = 1'b0;
  logic        reset, instrmem_rd, Data_rd, Data_req, load_en, load_sel;
  logic [15:0] pc, Data_addr, Data_din, load_addr, load_data;
  logic [15:0] idout [N];
  logic [15:0] ddout [N];
  logic        ci [N];
  logic        cd [N];

  always #5 clock = ~clock;

  for (genvar g = 0; g < N; g++) begin : g_dut
    lc3_mem_responder #(.IMEM_AW(8), .DMEM_AW(8), .WAIT_CYCLES(g)) dut (
      .clock(clock), .reset(reset),
      .pc(pc), .instrmem_rd(instrmem_rd), .Instr_dout(idout[g]), .complete_instr(ci[g]),
      .Data_addr(Data_addr), .Data_din(Data_din), .Data_rd(Data_rd), .Data_req(Data_req),
      .Data_dout(ddout[g]), .complete_data(cd[g]),
      .load_en(load_en), .load_sel(load_sel), .load_addr(load_addr), .load_data(load_data)
    );
  end

  // Model: each side is busy until the cycle it completes in (done_at); idle otherwise.
  logic [15:0] mi [N][256];
  logic [15:0] md [N][256];
  int          cyc;
  int          i_done [N];
  int          d_done [N];
  logic [7:0]  ia [N];
  logic [7:0]  da [N];
  logic        drd [N];
  logic [15:0] ddin [N];
  logic [15:0] ih [N];
  logic [15:0] dh [N];
  int          tests, fails;

  task automatic chk(input string tag, input int k, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[W=%0d] cyc=%0d got=%h exp=%h", tag, k, cyc, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < N; k++) begin
      bit idle_i, idle_d;
      idle_i = i_done[k] < cyc;
      idle_d = d_done[k] < cyc;
      if (reset) begin
        i_done[k] = -1; d_done[k] = -1; ih[k] = 16'h0; dh[k] = 16'h0;
        continue;
      end
      if (i_done[k] == cyc) ih[k] = mi[k][ia[k]];
      if (d_done[k] == cyc) begin
        if (drd[k]) dh[k] = md[k][da[k]];
        else        md[k][da[k]] = ddin[k];
      end
      if (load_en && idle_i && idle_d) begin
        if (load_sel) md[k][load_addr[7:0]] = load_data;
        else          mi[k][load_addr[7:0]] = load_data;
      end
      if (idle_i && instrmem_rd) begin
        i_done[k] = cyc + k + 1; ia[k] = pc[7:0];
      end
      if (idle_d && Data_req) begin
        d_done[k] = cyc + k + 1; da[k] = Data_addr[7:0]; drd[k] = Data_rd; ddin[k] = Data_din;
      end
    end
    cyc++;
  endtask

  task automatic check_all();
    for (int k = 0; k < N; k++) begin
      bit eci, ecd;
      eci = (i_done[k] == cyc);
      ecd = (d_done[k] == cyc);
      chk("complete_instr", k, {15'b0, ci[k]}, {15'b0, eci});
      chk("Instr_dout", k, idout[k], eci ? mi[k][ia[k]] : ih[k]);
      chk("complete_data", k, {15'b0, cd[k]}, {15'b0, ecd});
      chk("Data_dout", k, ddout[k], (ecd && drd[k]) ? md[k][da[k]] : dh[k]);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    @(negedge clock);
    check_all();
    instrmem_rd = 1'b0; Data_req = 1'b0; load_en = 1'b0; reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0;
    for (int k = 0; k < N; k++) begin
      i_done[k] = -1; d_done[k] = -1; ih[k] = '0; dh[k] = '0;
      ia[k] = '0; da[k] = '0; drd[k] = 1'b0; ddin[k] = '0;
    end
    pc = '0; Data_addr = '0; Data_din = '0; load_addr = '0; load_data = '0;
    instrmem_rd = 0; Data_rd = 0; Data_req = 0; load_en = 0; load_sel = 0;

    reset = 1'b1; step();
    reset = 1'b1; step();
    for (int k = 0; k < N; k++) begin
      chk("rst_Instr_dout", k, idout[k], 16'h0000);
      chk("rst_Data_dout", k, ddout[k], 16'h0000);
      chk("rst_complete", k, {14'b0, ci[k], cd[k]}, 16'h0000);
    end

    // Fill both memories through the preload port (upper address bits random).
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 256; a++) begin
        load_en = 1'b1; load_sel = 1'(s);
        load_addr = {8'($urandom), 8'(a)}; load_data = 16'($urandom);
        step();
      end

    // Fetch after preload, W=1: pulse exactly 2 cycles after the request.
    load_en = 1'b1; load_sel = 1'b0; load_addr = 16'h3000; load_data = 16'h1261; step();
    instrmem_rd = 1'b1; pc = 16'h3000; step();
    chk("fetch_early", 1, {15'b0, ci[1]}, 16'h0000);
    step();
    chk("fetch_pulse", 1, {15'b0, ci[1]}, 16'h0001);
    chk("fetch_data", 1, idout[1], 16'h1261);
    step();
    chk("fetch_one_cycle", 1, {15'b0, ci[1]}, 16'h0000);
    chk("fetch_hold", 1, idout[1], 16'h1261);
    idle(4);

    // Preload and fetch in the same idle cycle: fetch sees the new word.
    load_en = 1'b1; load_sel = 1'b0; load_addr = 16'h3000; load_data = 16'h1262;
    instrmem_rd = 1'b1; pc = 16'h3000; step();
    chk("wr_first_w0", 0, idout[0], 16'h1262);
    step();
    chk("wr_first_w1", 1, idout[1], 16'h1262);
    idle(4);

    // W=0 write then read of the same address.
    Data_req = 1'b1; Data_rd = 1'b0; Data_addr = 16'h0010; Data_din = 16'hBEEF; step();
    chk("w0_write_done", 0, {15'b0, cd[0]}, 16'h0001);
    step();
    Data_req = 1'b1; Data_rd = 1'b1; Data_addr = 16'h0010; step();
    chk("w0_read_done", 0, {15'b0, cd[0]}, 16'h0001);
    chk("w0_read_data", 0, ddout[0], 16'hBEEF);
    idle(4);

    // Address wrap-around.
    load_en = 1'b1; load_sel = 1'b1; load_addr = 16'h0010; load_data = 16'h00AA; step();
    Data_req = 1'b1; Data_rd = 1'b1; Data_addr = 16'h0110; step();
    chk("wrap_w0", 0, ddout[0], 16'h00AA);
    step();
    chk("wrap_w1", 1, ddout[1], 16'h00AA);
    idle(4);

    // W=3 write aborted by reset in the second wait cycle.
    load_en = 1'b1; load_sel = 1'b1; load_addr = 16'h0020; load_data = 16'h1234; step();
    Data_req = 1'b1; Data_rd = 1'b0; Data_addr = 16'h0020; Data_din = 16'h5555; step();
    step();
    reset = 1'b1; step();
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_pulse", 3, {15'b0, cd[3]}, 16'h0000);
      step();
    end
    Data_req = 1'b1; Data_rd = 1'b1; Data_addr = 16'h0020; idle(4);
    chk("abort_rd_done", 3, {15'b0, cd[3]}, 16'h0001);
    chk("abort_mem_kept", 3, ddout[3], 16'h1234);
    idle(2);

    // W=2 parallel fetch + read, preload while busy is dropped.
    load_en = 1'b1; load_sel = 1'b0; load_addr = 16'h0040; load_data = 16'h0F0F; step();
    load_en = 1'b1; load_sel = 1'b1; load_addr = 16'h0050; load_data = 16'h5A5A; step();
    instrmem_rd = 1'b1; pc = 16'h0040; Data_req = 1'b1; Data_rd = 1'b1; Data_addr = 16'h0050; step();
    load_en = 1'b1; load_sel = 1'b0; load_addr = 16'h0040; load_data = 16'hDEAD; step();
    step();
    chk("par_ci", 2, {15'b0, ci[2]}, 16'h0001);
    chk("par_cd", 2, {15'b0, cd[2]}, 16'h0001);
    chk("par_idata", 2, idout[2], 16'h0F0F);
    chk("par_ddata", 2, ddout[2], 16'h5A5A);
    idle(3);
    instrmem_rd = 1'b1; pc = 16'h0040; idle(3);
    chk("drop_preload", 2, idout[2], 16'h0F0F);
    idle(3);

    // Random traffic; low-16 data addresses make write->read hits common.
    for (int n = 0; n < 3000; n++) begin
      instrmem_rd = ($urandom_range(0, 2) == 0);
      pc          = 16'($urandom);
      Data_req    = ($urandom_range(0, 2) == 0);
      Data_rd     = 1'($urandom);
      Data_addr   = {8'($urandom), 4'h0, 4'($urandom)};
      Data_din    = 16'($urandom);
      reset       = ($urandom_range(0, 99) == 0);
      load_en     = !reset && ($urandom_range(0, 3) == 0);
      load_sel    = 1'($urandom);
      load_addr   = {8'($urandom), 4'h0, 4'($urandom)};
      load_data   = 16'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
